sync_fifo: RTL

Single-clock, parametrised FIFO for same-domain buffering, such as between the FMCW sample pipeline and the packetiser when both run on one clock, where an asynchronous FIFO's pointer synchronisers are pure overhead. Beyond a plain FIFO it adds:

- a fill-level output,
- programmable, fully registered almost-full and almost-empty thresholds,
- sticky overflow and underflow flags,
- a synchronous flush,
- a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/ram.sv | 28 ++
 rtl/sync_fifo.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ram.sv
// Simple dual-port storage: registered write, registered read (q updates only on rden).
// One-cycle read latency; no backpressure, caller guarantees legal addresses.
module ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             wrclk,
  input  logic             wren,
  input  logic [AW-1:0]    wraddress,
  input  logic [WIDTH-1:0] data,
  input  logic             rdclk,
  input  logic             rden,
  input  logic [AW-1:0]    rdaddress,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge wrclk) begin
    if (wren) r_mem[wraddress] <= data;
  end

  always_ff @(posedge rdclk) begin
    if (rden) q <= r_mem[rdaddress];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, registered almost flags, sticky over/underflow, flush, FWFT option.
// Standard read latency 1 cycle (FWFT: head visible 2 edges after write); writes refused while full.
module sync_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 1024,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int LVL_W      = ADDR_WIDTH + 1;

`ifdef SIMULATE
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end
`endif

  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0]      r_level, w_level_nxt, w_stor_cnt;
  logic                  r_full, r_af, r_empty, r_ae, r_ovf, r_unf;
  // Standard mode: rdata has been loaded at least once. FWFT mode: output register holds the head.
  logic                  r_q_vld;
  logic                  w_empty, w_wr_acc, w_rd_acc, w_rden, w_wren;
  logic [WIDTH-1:0]      w_q;

  assign w_empty    = (FWFT != 0) ? !r_q_vld : r_empty;
  assign w_wr_acc   = wen && !r_full;
  assign w_rd_acc   = ren && !w_empty;
  assign w_stor_cnt = r_level - LVL_W'(r_q_vld);
  assign w_rden     = !clr && ((FWFT != 0) ? ((w_stor_cnt != '0) && (!r_q_vld || w_rd_acc))
                                           : w_rd_acc);
  assign w_wren     = !clr && w_wr_acc;

  always_comb begin
    w_level_nxt = r_level;
    if (clr) begin
      w_level_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_empty <= 1'b1;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_q_vld <= 1'b0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_empty <= 1'b1;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_q_vld <= (FWFT != 0) ? 1'b0 : r_q_vld;
    end else begin
      if (w_wren) r_wptr <= r_wptr + 1'b1;
      if (w_rden) r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(DEPTH));
      r_af    <= (w_level_nxt >= LVL_W'(AF_THRESH));
      r_empty <= (w_level_nxt == '0);
      r_ae    <= (w_level_nxt <= LVL_W'(AE_THRESH));
      if (wen && r_full)  r_ovf <= 1'b1;
      if (ren && w_empty) r_unf <= 1'b1;
      if (FWFT != 0) begin
        if (w_rden)        r_q_vld <= 1'b1;
        else if (w_rd_acc) r_q_vld <= 1'b0;
      end else if (w_rd_acc) begin
        r_q_vld <= 1'b1;
      end
    end
  end

  ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .wrclk     (clk),
    .wren      (w_wren),
    .wraddress (r_wptr),
    .data      (wdata),
    .rdclk     (clk),
    .rden      (w_rden),
    .rdaddress (r_rptr),
    .q         (w_q)
  );

  assign rdata        = r_q_vld ? w_q : '0;
  assign empty        = w_empty;
  assign full         = r_full;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule
